// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage MIPS32 pipeline: load-use stalls, taken-branch
// squashes, bounded memory-wait freezes and saturating stall/flush counters.
module hazard_control_unit #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd16,
  parameter int         CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             MemRead_EX,
  input  logic [4:0]       Rt_EX,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             Uses_Rt_ID,
  input  logic             Branch_Taken_MEM,
  input  logic             Mem_Access_MEM,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Bubble,
  output logic             Pipeline_Freeze,
  output logic [1:0]       State,
  output logic             Mem_Error,
  output logic [CNT_W-1:0] Stall_Cycles,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;

  logic [1:0]       r_state;
  logic [7:0]       r_waitCnt;
  logic             r_memError;
  logic [CNT_W-1:0] r_stallCycles;
  logic [CNT_W-1:0] r_flushCount;

  logic       w_loadUse;
  logic       w_memStall;
  logic [1:0] w_nextState;
  logic [7:0] w_nextWaitCnt;
  logic       w_setError;
  logic       w_flushInc;

  assign w_loadUse  = MemRead_EX && (Rt_EX != 5'd0) &&
                      ((Rt_EX == Rs_ID) || (Uses_Rt_ID && (Rt_EX == Rt_ID)));
  assign w_memStall = Mem_Access_MEM && !Mem_Ready;

  assign State        = r_state;
  assign Mem_Error    = r_memError;
  assign Stall_Cycles = r_stallCycles;
  assign Flush_Count  = r_flushCount;

  // Control outputs and next-state decode; everything stays at defaults while Reset is high.
  always_comb begin
    PC_Write        = 1'b1;
    IF_ID_Write     = 1'b1;
    IF_ID_Flush     = 1'b0;
    ID_EX_Bubble    = 1'b0;
    EX_MEM_Bubble   = 1'b0;
    Pipeline_Freeze = 1'b0;
    w_nextState     = r_state;
    w_nextWaitCnt   = r_waitCnt;
    w_setError      = 1'b0;
    w_flushInc      = 1'b0;
    if (!Reset) begin
      case (r_state)
        S_RUN: begin
          if (Branch_Taken_MEM) begin
            IF_ID_Flush   = 1'b1;
            ID_EX_Bubble  = 1'b1;
            EX_MEM_Bubble = 1'b1;
            w_nextState   = S_FLUSH;
            w_flushInc    = 1'b1;
          end else if (w_memStall) begin
            Pipeline_Freeze = 1'b1;
            PC_Write        = 1'b0;
            IF_ID_Write     = 1'b0;
            w_nextState     = S_MEM_WAIT;
            w_nextWaitCnt   = 8'd1;
          end else if (w_loadUse) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end
        end
        S_MEM_WAIT: begin
          if (w_memStall && (r_waitCnt < MEM_TIMEOUT)) begin
            Pipeline_Freeze = 1'b1;
            PC_Write        = 1'b0;
            IF_ID_Write     = 1'b0;
            w_nextWaitCnt   = r_waitCnt + 8'd1;
          end else begin
            // A still-pending access here has hit the timeout and is abandoned.
            w_setError    = w_memStall;
            w_nextState   = S_RUN;
            w_nextWaitCnt = 8'd0;
          end
        end
        S_FLUSH: begin
          w_nextState = S_RUN;
          if (w_loadUse) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end
        end
        default: begin
          w_nextState   = S_RUN;
          w_nextWaitCnt = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_RUN;
      r_waitCnt     <= 8'd0;
      r_memError    <= 1'b0;
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      if (w_setError) r_memError <= 1'b1;
      if (!PC_Write && (r_stallCycles != '1)) r_stallCycles <= r_stallCycles + CNT_W'(1);
      if (w_flushInc && (r_flushCount != '1)) r_flushCount <= r_flushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the stall/flush rules.
module tb_hazard_control_unit;

  localparam logic [7:0] TB_TIMEOUT = 8'd4;
  localparam int         TB_CNT_W   = 4;
  localparam int         SAT        = (1 << TB_CNT_W) - 1;

  localparam logic [5:0] C_DEFAULT = 6'b110000;
  localparam logic [5:0] C_STALL   = 6'b000100;
  localparam logic [5:0] C_FREEZE  = 6'b000001;
  localparam logic [5:0] C_FLUSH   = 6'b111110;

  logic Clk = 1'b0;
  logic Reset = 1'b1, MemRead_EX = 1'b0, Uses_Rt_ID = 1'b0;
  logic Branch_Taken_MEM = 1'b0, Mem_Access_MEM = 1'b0, Mem_Ready = 1'b0;
  logic [4:0] Rt_EX = 5'd0, Rs_ID = 5'd0, Rt_ID = 5'd0;
  logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble, Pipeline_Freeze;
  logic [1:0] State;
  logic Mem_Error;
  logic [TB_CNT_W-1:0] Stall_Cycles, Flush_Count;
  logic [5:0] ctrl;

  // Staged inputs, copied onto the DUT pins at the falling edge.
  logic sRst, sMemRead, sUsesRt, sBranch, sAccess, sReady;
  logic [4:0] sRtEx, sRsId, sRtId;

  // Model state: freeze cycles spent on the current access (0 = none), pending flush cycle.
  int mWaitFreezes = 0, nWaitFreezes = 0;
  bit mFlushNext = 0, nFlushNext = 0;
  logic mErr = 1'b0, nErr = 1'b0;
  logic [31:0] mStall = 0, nStall = 0, mFlush = 0, nFlush = 0;
  logic [5:0] expCtrl;
  logic [1:0] expState;

  int nVectors = 0;
  int nChecks = 0;
  int nMiscompares = 0;

  hazard_control_unit #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX), .Rs_ID(Rs_ID),
    .Rt_ID(Rt_ID), .Uses_Rt_ID(Uses_Rt_ID), .Branch_Taken_MEM(Branch_Taken_MEM),
    .Mem_Access_MEM(Mem_Access_MEM), .Mem_Ready(Mem_Ready), .PC_Write(PC_Write),
    .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble),
    .EX_MEM_Bubble(EX_MEM_Bubble), .Pipeline_Freeze(Pipeline_Freeze), .State(State),
    .Mem_Error(Mem_Error), .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count)
  );

  assign ctrl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble, Pipeline_Freeze};

  always #5 Clk = ~Clk;

  task automatic clearInputs();
    sRst = 0; sMemRead = 0; sUsesRt = 0; sBranch = 0; sAccess = 0; sReady = 0;
    sRtEx = 0; sRsId = 0; sRtId = 0;
  endtask

  // Expected outputs for this cycle and the model state after the coming edge.
  task automatic modelEval();
    bit loadUse, memStall;
    loadUse  = sMemRead && sRtEx != 0 && (sRtEx == sRsId || (sUsesRt && sRtEx == sRtId));
    memStall = sAccess && !sReady;
    expCtrl  = C_DEFAULT;
    expState = mFlushNext ? 2'd2 : (mWaitFreezes > 0 ? 2'd1 : 2'd0);
    nWaitFreezes = mWaitFreezes; nFlushNext = 0; nErr = mErr; nStall = mStall; nFlush = mFlush;
    if (sRst) begin
      nWaitFreezes = 0; nErr = 0; nStall = 0; nFlush = 0;
    end else begin
      if (mFlushNext) begin
        if (loadUse) expCtrl = C_STALL;
      end else if (mWaitFreezes > 0) begin
        if (memStall && mWaitFreezes < int'(TB_TIMEOUT)) begin
          expCtrl = C_FREEZE;
          nWaitFreezes = mWaitFreezes + 1;
        end else begin
          if (memStall) nErr = 1;
          nWaitFreezes = 0;
        end
      end else if (sBranch) begin
        expCtrl = C_FLUSH;
        nFlushNext = 1;
        nFlush = (mFlush < SAT) ? mFlush + 1 : mFlush;
      end else if (memStall) begin
        expCtrl = C_FREEZE;
        nWaitFreezes = 1;
      end else if (loadUse) begin
        expCtrl = C_STALL;
      end
      if (!expCtrl[5]) nStall = (mStall < SAT) ? mStall + 1 : mStall;
    end
  endtask

  task automatic applyStimulus();
    mWaitFreezes = nWaitFreezes; mFlushNext = nFlushNext; mErr = nErr;
    mStall = nStall; mFlush = nFlush;
    @(negedge Clk);
    Reset = sRst; MemRead_EX = sMemRead; Uses_Rt_ID = sUsesRt; Branch_Taken_MEM = sBranch;
    Mem_Access_MEM = sAccess; Mem_Ready = sReady; Rt_EX = sRtEx; Rs_ID = sRsId; Rt_ID = sRtId;
    #1;
    modelEval();
    nVectors++;
  endtask

  task automatic resetDut();
    clearInputs(); sRst = 1;
    applyStimulus();
    clearInputs();
  endtask

  task automatic test_reset();
    clearInputs(); sRst = 1;
    applyStimulus();
    applyStimulus();
    nChecks++;
    if (ctrl !== C_DEFAULT) begin nMiscompares++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, C_DEFAULT); end
    clearInputs();
    applyStimulus();
    nChecks++;
    if (State !== 2'd0 || Mem_Error !== 1'b0 || Stall_Cycles !== 0 || Flush_Count !== 0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_regs: got state=%0d err=%b stall=%0d flush=%0d expected 0/0/0/0", State, Mem_Error, Stall_Cycles, Flush_Count);
    end
  endtask

  task automatic test_load_use();
    resetDut();
    sMemRead = 1; sRtEx = 5; sRsId = 5;
    applyStimulus();
    nChecks++;
    if (ctrl !== C_STALL || ctrl !== expCtrl) begin nMiscompares++; $display("[TB] FAIL load_use_rs: got %b expected %b", ctrl, C_STALL); end
    clearInputs();
    applyStimulus();
    nChecks++;
    if (ctrl !== C_DEFAULT || Stall_Cycles !== 1) begin nMiscompares++; $display("[TB] FAIL load_use_release: got ctrl=%b stall=%0d expected %b/1", ctrl, Stall_Cycles, C_DEFAULT); end
    sMemRead = 1; sRtEx = 0; sRsId = 0;
    applyStimulus();
    nChecks++;
    if (ctrl !== C_DEFAULT) begin nMiscompares++; $display("[TB] FAIL load_use_r0: got %b expected %b", ctrl, C_DEFAULT); end
    sRtEx = 7; sRtId = 7; sRsId = 3; sUsesRt = 0;
    applyStimulus();
    nChecks++;
    if (ctrl !== C_DEFAULT) begin nMiscompares++; $display("[TB] FAIL rt_unused: got %b expected %b", ctrl, C_DEFAULT); end
    sUsesRt = 1;
    applyStimulus();
    nChecks++;
    if (ctrl !== C_STALL) begin nMiscompares++; $display("[TB] FAIL rt_used: got %b expected %b", ctrl, C_STALL); end
    clearInputs();
    applyStimulus();
    nChecks++;
    if (Stall_Cycles !== 2 || 32'(Stall_Cycles) !== mStall) begin nMiscompares++; $display("[TB] FAIL load_use_count: got %0d expected 2", Stall_Cycles); end
  endtask

  task automatic test_branch_flush();
    resetDut();
    sBranch = 1; sAccess = 1; sReady = 0;
    applyStimulus();
    nChecks++;
    if (ctrl !== C_FLUSH || State !== 2'd0) begin nMiscompares++; $display("[TB] FAIL branch_flush: got ctrl=%b state=%0d expected %b/0", ctrl, State, C_FLUSH); end
    clearInputs();
    applyStimulus();
    nChecks++;
    if (State !== 2'd2 || ctrl !== C_DEFAULT || Flush_Count !== 1) begin nMiscompares++; $display("[TB] FAIL flush_state: got state=%0d ctrl=%b cnt=%0d expected 2/%b/1", State, ctrl, Flush_Count, C_DEFAULT); end
    applyStimulus();
    nChecks++;
    if (State !== 2'd0) begin nMiscompares++; $display("[TB] FAIL flush_return: got %0d expected 0", State); end
  endtask

  task automatic test_mem_wait();
    resetDut();
    sAccess = 1; sReady = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      nChecks++;
      if (ctrl !== C_FREEZE) begin nMiscompares++; $display("[TB] FAIL mem_wait_freeze%0d: got %b expected %b", i, ctrl, C_FREEZE); end
    end
    sReady = 1;
    applyStimulus();
    nChecks++;
    if (ctrl !== C_DEFAULT || State !== 2'd1) begin nMiscompares++; $display("[TB] FAIL mem_wait_ready: got ctrl=%b state=%0d expected %b/1", ctrl, State, C_DEFAULT); end
    clearInputs();
    applyStimulus();
    nChecks++;
    if (State !== 2'd0 || Stall_Cycles !== 3 || Mem_Error !== 1'b0) begin nMiscompares++; $display("[TB] FAIL mem_wait_after: got state=%0d stall=%0d err=%b expected 0/3/0", State, Stall_Cycles, Mem_Error); end
  endtask

  task automatic test_timeout();
    int freezes;
    freezes = 0;
    resetDut();
    sAccess = 1; sReady = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      if (Pipeline_Freeze === 1'b1) freezes++;
      nChecks++;
      if (ctrl !== expCtrl) begin nMiscompares++; $display("[TB] FAIL timeout_cycle%0d: got %b expected %b", i, ctrl, expCtrl); end
    end
    clearInputs();
    applyStimulus();
    nChecks++;
    if (freezes != int'(TB_TIMEOUT) || Mem_Error !== 1'b1 || State !== 2'd0) begin nMiscompares++; $display("[TB] FAIL timeout_release: got freezes=%0d err=%b state=%0d expected %0d/1/0", freezes, Mem_Error, State, TB_TIMEOUT); end
    for (int i = 0; i < 5; i++) applyStimulus();
    nChecks++;
    if (Mem_Error !== 1'b1) begin nMiscompares++; $display("[TB] FAIL timeout_sticky: got %b expected 1", Mem_Error); end
    resetDut();
    applyStimulus();
    nChecks++;
    if (Mem_Error !== 1'b0) begin nMiscompares++; $display("[TB] FAIL timeout_clear: got %b expected 0", Mem_Error); end
  endtask

  task automatic test_reset_mid_wait();
    resetDut();
    sAccess = 1; sReady = 0;
    applyStimulus();
    applyStimulus();
    sRst = 1;
    applyStimulus();
    nChecks++;
    if (ctrl !== C_DEFAULT || State !== 2'd1) begin nMiscompares++; $display("[TB] FAIL reset_wait_ctrl: got ctrl=%b state=%0d expected %b/1", ctrl, State, C_DEFAULT); end
    clearInputs();
    applyStimulus();
    nChecks++;
    if (State !== 2'd0 || ctrl !== C_DEFAULT || Stall_Cycles !== 0 || Flush_Count !== 0) begin nMiscompares++; $display("[TB] FAIL reset_wait_after: got state=%0d ctrl=%b stall=%0d flush=%0d expected 0/%b/0/0", State, ctrl, Stall_Cycles, Flush_Count, C_DEFAULT); end
  endtask

  task automatic test_saturation();
    resetDut();
    sMemRead = 1; sRtEx = 3; sRsId = 3;
    for (int i = 0; i < SAT + 5; i++) applyStimulus();
    clearInputs();
    applyStimulus();
    nChecks++;
    if (32'(Stall_Cycles) !== SAT) begin nMiscompares++; $display("[TB] FAIL stall_saturate: got %0d expected %0d", Stall_Cycles, SAT); end
    for (int i = 0; i < SAT + 5; i++) begin
      sBranch = 1; applyStimulus();
      sBranch = 0; applyStimulus();
    end
    applyStimulus();
    nChecks++;
    if (32'(Flush_Count) !== SAT) begin nMiscompares++; $display("[TB] FAIL flush_saturate: got %0d expected %0d", Flush_Count, SAT); end
  endtask

  task automatic test_random();
    resetDut();
    for (int i = 0; i < 600; i++) begin
      sRst     = ($urandom_range(0, 59) == 0);
      sMemRead = $urandom_range(0, 1) == 1;
      sUsesRt  = $urandom_range(0, 1) == 1;
      sBranch  = ($urandom_range(0, 9) == 0);
      sAccess  = ($urandom_range(0, 2) != 0);
      sReady   = ($urandom_range(0, 3) == 0);
      sRtEx    = 5'($urandom_range(0, 3));
      sRsId    = 5'($urandom_range(0, 3));
      sRtId    = 5'($urandom_range(0, 3));
      applyStimulus();
      nChecks++;
      if (ctrl !== expCtrl || State !== expState || Mem_Error !== mErr ||
          32'(Stall_Cycles) !== mStall || 32'(Flush_Count) !== mFlush) begin
        nMiscompares++;
        $display("[TB] FAIL random%0d: got ctrl=%b st=%0d err=%b stall=%0d flush=%0d expected ctrl=%b st=%0d err=%b stall=%0d flush=%0d",
                 i, ctrl, State, Mem_Error, Stall_Cycles, Flush_Count, expCtrl, expState, mErr, mStall, mFlush);
      end
    end
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_load_use();
    test_branch_flush();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
